// File: rtl/apb_decode_bridge.sv
// apb_decode_bridge: registered APB fan-out that decodes, replays and returns one transfer at a time; APB_DECODE_BRIDGE_TIMEOUT_EN enables the hung-slave timeout.
module apb_decode_bridge #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int          REGION_SHIFT   = 10,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_psel,
  input  logic                       s_penable,
  input  logic                       s_pwrite,
  input  logic [31:0]                s_paddr,
  input  logic [31:0]                s_pwdata,
  output logic [31:0]                s_prdata,
  output logic                       s_pready,
  output logic                       s_pslverr,
  output logic [NUM_SLAVES-1:0]      m_psel,
  output logic                       m_penable,
  output logic                       m_pwrite,
  output logic [31:0]                m_paddr,
  output logic [31:0]                m_pwdata,
  input  logic [NUM_SLAVES*32-1:0]   m_prdata,
  input  logic [NUM_SLAVES-1:0]      m_pready,
  input  logic [NUM_SLAVES-1:0]      m_pslverr
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam logic [NUM_SLAVES-1:0] one = NUM_SLAVES'(1);
  localparam logic [31:0] err_word = 32'hBADD_C0DE;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, next;
  logic [IW-1:0] idx;
  logic [31:0] off, slot, resp_data;
  logic [31:0] rd_arr [NUM_SLAVES];
  logic resp_err, pwrite_q, start, dec_err, hit, tmo;
  if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("apb_decode_bridge: parameter out of range");
  end
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_rd
    assign rd_arr[i] = m_prdata[32*i +: 32];
  end
  assign off     = s_paddr - BASE_ADDR;
  assign slot    = off >> REGION_SHIFT;
  assign start   = state == IDLE && s_psel && !s_penable;
  assign dec_err = s_paddr < BASE_ADDR || slot >= 32'(NUM_SLAVES);
  assign hit     = state == ACCESS && m_pready[idx];
`ifdef APB_DECODE_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && cnt != 8'hff) cnt <= cnt + 8'd1;
  // cnt counts completed ACCESS cycles, so the limit is hit on the last allowed one
  assign tmo = state == ACCESS && !m_pready[idx] && cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = start ? (dec_err ? RESP : SETUP) : IDLE;
      SETUP:   next = ACCESS;
      ACCESS:  next = hit || tmo ? RESP : ACCESS;
      default: next = IDLE;
    endcase
  end
  assign m_psel    = state == SETUP || state == ACCESS ? one << idx : '0;
  assign m_penable = state == ACCESS;
  assign m_pwrite  = state != IDLE && pwrite_q;
  assign s_pready  = state == RESP;
  assign s_prdata  = s_pready ? resp_data : '0;
  assign s_pslverr = s_pready && resp_err;
  // the response defaults to the error word so decode errors and timeouts need no extra path
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      pwrite_q  <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= next;
      if (start) begin
        m_paddr   <= s_paddr;
        m_pwdata  <= s_pwdata;
        pwrite_q  <= s_pwrite;
        idx       <= slot[IW-1:0];
        resp_data <= err_word;
        resp_err  <= 1'b1;
      end
      if (hit) begin
        resp_data <= pwrite_q ? '0 : rd_arr[idx];
        resp_err  <= m_pslverr[idx];
      end
    end
endmodule

// File: doc/apb_decode_bridge.md
# apb_decode_bridge

- Registered APB fan-out stage between the system APB master and the per-block register slaves (each a 1 KB window decoded with `paddr & 32'h3ff`).
- Latches one upstream transfer and decodes its address to exactly one of NUM_SLAVES downstream ports.
- Replays the transfer there with a full SETUP/ACCESS sequence and returns the captured response upstream.
- Unmapped addresses and hung slaves are terminated locally with an error response.

## Interface
One clock; reset is asynchronous and active-high.

Parameters:
- NUM_SLAVES, 4, number of downstream ports (1..16)
- BASE_ADDR, 32'h0, address of slave 0 window
- REGION_SHIFT, 10, log2 of window size (1 KB)
- TIMEOUT_CYCLES, 255, max ACCESS cycles before forced error (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- s_psel  in  1  upstream select
- s_penable  in  1  upstream enable
- s_pwrite  in  1  upstream write
- s_paddr  in  32  upstream address
- s_pwdata  in  32  upstream write data
- s_prdata  out  32  upstream read data
- s_pready  out  1  upstream ready
- s_pslverr  out  1  upstream error
- m_psel  out  NUM_SLAVES  one-hot downstream select
- m_penable  out  1  downstream enable, shared
- m_pwrite  out  1  downstream write, shared
- m_paddr  out  32  latched full address, shared
- m_pwdata  out  32  latched write data, shared
- m_prdata  in  NUM_SLAVES*32  slave i read data at [32*i+31:32*i]
- m_pready  in  NUM_SLAVES  per-slave ready
- m_pslverr  in  NUM_SLAVES  per-slave error

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE, on `s_psel & !s_penable`:
  - Latch paddr, pwdata, pwrite.
  - Compute `off = s_paddr - BASE_ADDR` and `idx = off >> REGION_SHIFT`.
  - If `s_paddr < BASE_ADDR` or `idx >= NUM_SLAVES`: decode error. Load resp_data = 32'hBADD_C0DE and resp_err = 1, then go to RESP.
  - Otherwise latch idx and go to SETUP.
- SETUP: m_psel[idx] = 1, m_penable = 0. Go to ACCESS next cycle.
- ACCESS:
  - m_psel[idx] = 1, m_penable = 1; the timeout counter increments each cycle.
  - When m_pready[idx] = 1: capture the m_prdata slice and m_pslverr[idx] (write transfers capture prdata as 0), then go to RESP.
- RESP:
  - s_pready = 1 for exactly one cycle, driving s_prdata = resp_data and s_pslverr = resp_err; m_psel is all zero.
  - Go to IDLE.
- s_prdata and s_pslverr are 0 whenever s_pready is 0.
- m_paddr and m_pwdata hold their latched values from SETUP through RESP; m_pwrite is 0 in IDLE.
- Upstream signal changes after the latch are ignored until IDLE; an upstream abort does not cancel the downstream transfer.
- A new upstream SETUP in the RESP cycle is not accepted; it is accepted in IDLE on the next cycle.

## Timing
- Reset (async assert, sync release): state = IDLE. All outputs 0: s_prdata, s_pready, s_pslverr, m_psel, m_penable, m_pwrite, m_paddr, m_pwdata. Timeout counter = 0.
- Reset asserted mid-transfer drops m_psel/m_penable immediately; no response is produced.
- Mapped transfer, upstream setup at cycle T:
  - SETUP at T+1, ACCESS from T+2.
  - If slave ready arrives at T+2+k, s_pready is asserted at T+3+k.
  - Zero-wait slave: s_pready at T+3.
- Decode error: s_pready at T+1.
- Throughput: at most one transfer per 4 cycles for a zero-wait slave.
- The timeout counter is an 8-bit saturating counter, cleared on entering ACCESS.
- Ready and timeout in the same cycle: ready wins and the slave response is returned.

## Configuration
- Macro: APB_DECODE_BRIDGE_TIMEOUT_EN.
- Defined: when the counter reaches TIMEOUT_CYCLES in ACCESS with no ready, m_psel and m_penable drop, resp_data = 32'hBADD_C0DE, resp_err = 1, and the FSM goes to RESP.
- Undefined: the counter is not built and ACCESS waits indefinitely for m_pready[idx].

## Test plan
- Read 0x404 with slave 1 returning 32'h1234_5678 zero-wait -> m_psel = 4'b0010 at T+1 and T+2, m_penable only at T+2; s_pready at T+3 with s_prdata = 32'h1234_5678 and s_pslverr = 0.
- Write 0xC1C, data 32'hDEAD_BEEF, slave 3 ready after 2 waits -> m_pwdata = 32'hDEAD_BEEF and m_pwrite = 1 throughout; s_pready at T+5 with s_prdata = 0.
- Read 0x1000 with NUM_SLAVES = 4 -> no m_psel activity; s_pready at T+1 with s_prdata = 32'hBADD_C0DE and s_pslverr = 1.
- Slave 2 returns m_pslverr = 1 with its ready -> s_pslverr = 1 on the s_pready cycle.
- With TIMEOUT_EN and TIMEOUT_CYCLES = 8, slave 0 never ready -> m_psel drops after 8 ACCESS cycles; s_pready on the next cycle with 32'hBADD_C0DE and s_pslverr = 1. A following read of 0x000 with ready completes normally.
- rst asserted during ACCESS -> all outputs 0 the same cycle; after release, a read of 0x404 completes normally at T+3.
